branch_resolve_unit: RTL and testbench
======================================

# branch_resolve_unit

Decode-side producer of the redirect interface into the PC sequencer. Takes the 16-bit instruction in the decode slot plus ALU condition flags, evaluates branch conditions against an internal NZCV flag register, and drives registered branch-type/offset/redirect outputs one cycle later. Sequences wrong-path flushes of the fetch and decode stages after every taken branch.

## Interface
Parameters:
- FLUSH_CYCLES, 2, wrong-path cycles squashed after a taken branch (legal 1–3)

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high
- instr  in  16  instruction in the decode slot
- instr_valid  in  1  instr holds a real instruction this cycle
- stall  in  1  pipeline freeze; unit holds all state
- alu_flags  in  4  {N,Z,C,V} from execute
- flags_we  in  1  commit alu_flags into the flag register this cycle
- register_data_2  in  16  register-file read data for register branches
- cond_address  out  8  signed conditional offset
- uncond_address  out  11  signed unconditional offset
- link_address  out  6  link target field
- reg_target  out  16  latched register_data_2 for register branch
- branch_type  out  2  00 cond, 01 uncond, 10 link, 11 register
- BrTaken  out  1  one-cycle redirect pulse
- reg_branch  out  1  redirect source is reg_target
- link_pc_we  out  1  one-cycle pulse: write link PC (link branch taken)
- flush_if, flush_id  out  1  squash fetch / decode slots
- stall_req  out  1  hold decode slot one cycle (flag hazard, see Configuration)

## Operation
- Decode (instr[15:11]): 1100x cond (cond=instr[11:8], offset=instr[7:0]); 11010 uncond (instr[10:0]); 11011 link (instr[5:0], instr[10:6] ignored); 11100 register; all else non-branch.
- Conditions: 0000 Z; 0001 !Z; 0010 N^V; 0011 !(N^V); 0100 !C; 0101 C; 0110 N; 1110 always; all other codes never taken.
- Uncond, link, register branches always taken.
- Flag register: 4 bits, reset 0, loads alu_flags when flags_we & !stall.
- FSM states IDLE, FLUSH. IDLE: valid branch with !stall & !stall_req is resolved; taken -> FLUSH with counter=FLUSH_CYCLES. FLUSH: instr_valid ignored (wrong path); counter decrements each non-stalled cycle; 0 -> IDLE.
- On resolve: offset fields, branch_type, reg_target latch; address outputs hold last value otherwise. Not-taken cond: branch_type=00, BrTaken=0, no flush.
- reg_branch=1 only with BrTaken for register branch; link_pc_we only with BrTaken for link.
- Reset values: all outputs 0, branch_type 00, FSM IDLE, flags 0000.

## Timing
- Resolve in cycle N -> outputs valid cycle N+1 (latency 1, registered).
- BrTaken, reg_branch, link_pc_we: exactly one cycle (N+1), never stretched by stall.
- flush_if, flush_id high cycles N+1 through N+FLUSH_CYCLES (stalled cycles extend the window).
- stall high: FSM, counter, flags, outputs frozen; pulses already issued still drop after one cycle.
- Branch arriving during FLUSH: discarded, no redirect.
- Reset mid-FLUSH: IDLE and all outputs 0 at next edge.
- flags_we and conditional branch same cycle: see Configuration.

## Configuration
- FLAG_BYPASS_EN defined: condition evaluation uses alu_flags when flags_we is high in the resolve cycle; stall_req tied 0.
- Undefined: stall_req asserts combinationally for one cycle on that collision; upstream holds instr; branch resolves next cycle from the updated flag register (latency +1).

## Test plan
- Reset asserted with a branch in decode -> all outputs 0, no BrTaken; release -> IDLE.
- Flags Z=1, instr 0xC005 (EQ, +5) -> N+1: BrTaken=1, branch_type=00, cond_address=0x05; flush_if/flush_id high 2 cycles.
- Flags Z=0, instr 0xC1FE (NE, -2) taken; then Z=1 same instr -> no BrTaken, no flush.
- instr 0xE000, register_data_2=0x1234 -> BrTaken=1, reg_branch=1, branch_type=11, reg_target=0x1234; branch following in FLUSH ignored.
- flags_we with Z=1 plus 0xC003 same cycle -> bypass build: taken at N+1; non-bypass: stall_req at N, taken at N+2.
- instr 0xD82A with stall pulses inside FLUSH -> link_address=0x2A, link_pc_we one cycle, flush window extended by stalled cycles.

Source files
------------

// File: rtl/branch_resolve_unit.sv
// Decode-side branch resolver: evaluates conditions, drives registered redirect
// outputs and sequences wrong-path flushes. FLAG_BYPASS_EN forwards alu_flags.
module branch_resolve_unit #(
    parameter int FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] instr,
    input  logic        instr_valid,
    input  logic        stall,
    input  logic [3:0]  alu_flags,
    input  logic        flags_we,
    input  logic [15:0] register_data_2,
    output logic [7:0]  cond_address,
    output logic [10:0] uncond_address,
    output logic [5:0]  link_address,
    output logic [15:0] reg_target,
    output logic [1:0]  branch_type,
    output logic        BrTaken,
    output logic        reg_branch,
    output logic        link_pc_we,
    output logic        flush_if,
    output logic        flush_id,
    output logic        stall_req
);

    typedef enum logic {
        IDLE,
        FLUSH
    } state_t;

    state_t     state;
    state_t     state_nx;
    logic [1:0] cnt;
    logic [1:0] cnt_nx;
    logic [3:0] flags;
    logic [3:0] eval_flags;
    logic       is_cond;
    logic       is_unc;
    logic       is_link;
    logic       is_reg;
    logic       is_br;
    logic [1:0] br_code;
    logic       cond_ok;
    logic       taken;
    logic       resolve;

    always_comb begin
        is_cond = (instr[15:12] == 4'b1100);
        is_unc  = (instr[15:11] == 5'b11010);
        is_link = (instr[15:11] == 5'b11011);
        is_reg  = (instr[15:11] == 5'b11100);
        is_br   = is_cond | is_unc | is_link | is_reg;
    end

    always_comb begin
        br_code = 2'b00;
        unique case (1'b1)
            is_unc:  br_code = 2'b01;
            is_link: br_code = 2'b10;
            is_reg:  br_code = 2'b11;
            default: br_code = 2'b00;
        endcase
    end

`ifdef FLAG_BYPASS_EN
    assign eval_flags = flags_we ? alu_flags : flags;
    assign stall_req  = 1'b0;
`else
    assign eval_flags = flags;
    // Flag write racing a conditional branch: hold decode until flags settle
    assign stall_req  = !reset && (state == IDLE) && instr_valid
                        && is_cond && flags_we;
`endif

    // eval_flags = {N,Z,C,V}
    always_comb begin
        cond_ok = 1'b0;
        unique case (instr[11:8])
            4'h0:    cond_ok = eval_flags[2];
            4'h1:    cond_ok = !eval_flags[2];
            4'h2:    cond_ok = eval_flags[3] ^ eval_flags[0];
            4'h3:    cond_ok = !(eval_flags[3] ^ eval_flags[0]);
            4'h4:    cond_ok = !eval_flags[1];
            4'h5:    cond_ok = eval_flags[1];
            4'h6:    cond_ok = eval_flags[3];
            4'hE:    cond_ok = 1'b1;
            default: cond_ok = 1'b0;
        endcase
    end

    assign taken   = is_cond ? cond_ok : is_br;
    assign resolve = (state == IDLE) && instr_valid && is_br
                     && !stall && !stall_req;

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        if (!stall) begin
            unique case (state)
                IDLE: begin
                    if (resolve && taken) begin
                        state_nx = FLUSH;
                        cnt_nx   = 2'(FLUSH_CYCLES);
                    end
                end
                FLUSH: begin
                    if (cnt <= 2'd1) begin
                        state_nx = IDLE;
                        cnt_nx   = 2'd0;
                    end else begin
                        cnt_nx = cnt - 2'd1;
                    end
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= 2'd0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            flags <= 4'd0;
        end else if (flags_we && !stall) begin
            flags <= alu_flags;
        end
    end

    // Pulses clear every cycle so a stall never stretches them
    always_ff @(posedge clk) begin
        if (reset) begin
            cond_address   <= 8'd0;
            uncond_address <= 11'd0;
            link_address   <= 6'd0;
            reg_target     <= 16'd0;
            branch_type    <= 2'b00;
            BrTaken        <= 1'b0;
            reg_branch     <= 1'b0;
            link_pc_we     <= 1'b0;
        end else begin
            BrTaken    <= 1'b0;
            reg_branch <= 1'b0;
            link_pc_we <= 1'b0;
            if (resolve) begin
                branch_type <= br_code;
                BrTaken     <= taken;
                reg_branch  <= taken && is_reg;
                link_pc_we  <= taken && is_link;
                if (is_cond) cond_address <= instr[7:0];
                if (is_unc)  uncond_address <= instr[10:0];
                if (is_link) link_address <= instr[5:0];
                if (is_reg)  reg_target <= register_data_2;
            end
        end
    end

    assign flush_if = (state == FLUSH);
    assign flush_id = (state == FLUSH);

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Bench for branch_resolve_unit: directed scenarios plus random stimulus
// compared against a cycle-level behavioural model.
module tb_branch_resolve_unit;

    localparam int FC = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] instr = 16'd0;
    logic        instr_valid = 1'b0;
    logic        stall = 1'b0;
    logic [3:0]  alu_flags = 4'd0;
    logic        flags_we = 1'b0;
    logic [15:0] rd2 = 16'd0;
    logic [7:0]  cond_address;
    logic [10:0] uncond_address;
    logic [5:0]  link_address;
    logic [15:0] reg_target;
    logic [1:0]  branch_type;
    logic        BrTaken;
    logic        reg_branch;
    logic        link_pc_we;
    logic        flush_if;
    logic        flush_id;
    logic        stall_req;

    int checks = 0;
    int errors = 0;

    branch_resolve_unit #(.FLUSH_CYCLES(FC)) dut (
        .clk(clk),
        .reset(reset),
        .instr(instr),
        .instr_valid(instr_valid),
        .stall(stall),
        .alu_flags(alu_flags),
        .flags_we(flags_we),
        .register_data_2(rd2),
        .cond_address(cond_address),
        .uncond_address(uncond_address),
        .link_address(link_address),
        .reg_target(reg_target),
        .branch_type(branch_type),
        .BrTaken(BrTaken),
        .reg_branch(reg_branch),
        .link_pc_we(link_pc_we),
        .flush_if(flush_if),
        .flush_id(flush_id),
        .stall_req(stall_req)
    );

    always #5 clk = ~clk;

    // Behavioural model state
    logic [3:0]  mf;
    int          fl;
    logic [7:0]  m_ca;
    logic [10:0] m_ua;
    logic [5:0]  m_la;
    logic [15:0] m_rt;
    logic [1:0]  m_bt;
    logic        m_tk;
    logic        m_rb;
    logic        m_lpw;
    logic        e_sr;
    logic        o_sr;

    function automatic int kind(input logic [15:0] i);
        int op;
        op = int'(i[15:11]);
        if (op == 24 || op == 25) return 1;
        if (op == 26) return 2;
        if (op == 27) return 3;
        if (op == 28) return 4;
        return 0;
    endfunction

    function automatic bit cond_true(input logic [3:0] c, input logic [3:0] f);
        bit n, z, cf, v;
        n = f[3]; z = f[2]; cf = f[1]; v = f[0];
        case (c)
            4'h0: return z;
            4'h1: return !z;
            4'h2: return n != v;
            4'h3: return n == v;
            4'h4: return !cf;
            4'h5: return cf;
            4'h6: return n;
            4'hE: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [47:0] obs();
        return {cond_address, uncond_address, link_address, reg_target,
                branch_type, BrTaken, reg_branch, link_pc_we,
                flush_if, flush_id};
    endfunction

    function automatic logic [47:0] expv();
        logic f;
        f = (fl > 0);
        return {m_ca, m_ua, m_la, m_rt, m_bt, m_tk, m_rb, m_lpw, f, f};
    endfunction

    function automatic logic model_sr();
`ifdef FLAG_BYPASS_EN
        return 1'b0;
`else
        return !reset && fl == 0 && instr_valid
               && kind(instr) == 1 && flags_we;
`endif
    endfunction

    task automatic model_edge();
        int k;
        logic [3:0] ef;
        bit tk;
        k = kind(instr);
        if (reset) begin
            mf = 0; fl = 0; m_ca = 0; m_ua = 0; m_la = 0; m_rt = 0;
            m_bt = 0; m_tk = 0; m_rb = 0; m_lpw = 0;
            return;
        end
        m_tk = 0; m_rb = 0; m_lpw = 0;
        if (!stall) begin
            if (fl > 0) begin
                fl = fl - 1;
            end else if (instr_valid && k != 0 && !e_sr) begin
`ifdef FLAG_BYPASS_EN
                ef = flags_we ? alu_flags : mf;
`else
                ef = mf;
`endif
                tk = (k == 1) ? cond_true(instr[11:8], ef) : 1'b1;
                case (k)
                    1: begin m_ca = instr[7:0]; m_bt = 2'd0; end
                    2: begin m_ua = instr[10:0]; m_bt = 2'd1; end
                    3: begin m_la = instr[5:0]; m_bt = 2'd2; end
                    default: begin m_rt = rd2; m_bt = 2'd3; end
                endcase
                if (tk) begin
                    fl = FC;
                    m_tk = 1;
                    m_rb = (k == 4);
                    m_lpw = (k == 3);
                end
            end
            if (flags_we) mf = alu_flags;
        end
    endtask

    // Samples stall_req mid-cycle, advances one edge and the model
    task automatic tick();
        @(negedge clk);
        e_sr = model_sr();
        o_sr = stall_req;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic quiet();
        instr_valid = 0; flags_we = 0; stall = 0; instr = 16'd0;
    endtask

    task automatic test_reset();
        reset = 1; instr = 16'hE000; instr_valid = 1; rd2 = 16'hFFFF;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (obs() !== 48'd0) begin
                errors++;
                $display("FAIL reset_outputs: got %h want %h", obs(), 48'd0);
            end
        end
        reset = 0; quiet();
        tick();
        checks++;
        if (obs() !== expv() || flush_if !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: got %h want %h", obs(), expv());
        end
    endtask

    task automatic test_cond_eq();
        flags_we = 1; alu_flags = 4'b0100;
        tick();
        flags_we = 0; instr = 16'hC005; instr_valid = 1;
        tick();
        instr_valid = 0;
        checks++;
        if (BrTaken !== 1'b1 || branch_type !== 2'b00 ||
            cond_address !== 8'h05 || flush_if !== 1'b1) begin
            errors++;
            $display("FAIL eq_taken: got %h want taken/00/05/flush", obs());
        end
        for (int i = 0; i < FC + 1; i++) begin
            checks++;
            if (obs() !== expv()) begin
                errors++;
                $display("FAIL eq_window: got %h want %h", obs(), expv());
            end
            tick();
        end
        checks++;
        if (flush_if !== 1'b0 || flush_id !== 1'b0) begin
            errors++;
            $display("FAIL eq_flush_end: got %b%b want 00", flush_if, flush_id);
        end
    endtask

    task automatic test_cond_ne();
        flags_we = 1; alu_flags = 4'b0000;
        tick();
        flags_we = 0; instr = 16'hC1FE; instr_valid = 1;
        tick();
        instr_valid = 0;
        checks++;
        if (BrTaken !== 1'b1 || cond_address !== 8'hFE) begin
            errors++;
            $display("FAIL ne_taken: got %h want taken/FE", obs());
        end
        repeat (FC) tick();
        flags_we = 1; alu_flags = 4'b0100;
        tick();
        flags_we = 0; instr_valid = 1;
        tick();
        instr_valid = 0;
        checks++;
        if (BrTaken !== 1'b0 || flush_if !== 1'b0 || obs() !== expv()) begin
            errors++;
            $display("FAIL ne_not_taken: got %h want %h", obs(), expv());
        end
    endtask

    task automatic test_register();
        instr = 16'hE000; rd2 = 16'h1234; instr_valid = 1;
        tick();
        checks++;
        if (BrTaken !== 1'b1 || reg_branch !== 1'b1 ||
            branch_type !== 2'b11 || reg_target !== 16'h1234) begin
            errors++;
            $display("FAIL reg_branch: got %h want taken/reg/11/1234", obs());
        end
        instr = 16'hD811; rd2 = 16'h5555;
        tick();
        instr_valid = 0;
        checks++;
        if (BrTaken !== 1'b0 || link_pc_we !== 1'b0 ||
            branch_type !== 2'b11 || obs() !== expv()) begin
            errors++;
            $display("FAIL reg_flush_discard: got %h want %h", obs(), expv());
        end
        repeat (FC + 1) tick();
    endtask

    task automatic test_collision();
        flags_we = 1; alu_flags = 4'b0000;
        tick();
        alu_flags = 4'b0100; instr = 16'hC003; instr_valid = 1;
        tick();
`ifdef FLAG_BYPASS_EN
        instr_valid = 0; flags_we = 0;
        checks++;
        if (o_sr !== 1'b0 || BrTaken !== 1'b1 || cond_address !== 8'h03) begin
            errors++;
            $display("FAIL bypass_taken: got sr=%b %h want sr=0 taken/03", o_sr, obs());
        end
`else
        flags_we = 0;
        checks++;
        if (o_sr !== 1'b1 || BrTaken !== 1'b0) begin
            errors++;
            $display("FAIL collision_stall: got sr=%b br=%b want sr=1 br=0", o_sr, BrTaken);
        end
        tick();
        instr_valid = 0;
        checks++;
        if (o_sr !== 1'b0 || BrTaken !== 1'b1 || cond_address !== 8'h03) begin
            errors++;
            $display("FAIL collision_resolve: got sr=%b %h want sr=0 taken/03", o_sr, obs());
        end
`endif
        repeat (FC + 1) tick();
    endtask

    task automatic test_link_stall();
        int n;
        instr = 16'hD82A; instr_valid = 1;
        tick();
        instr_valid = 0;
        checks++;
        if (link_pc_we !== 1'b1 || link_address !== 6'h2A ||
            branch_type !== 2'b10 || BrTaken !== 1'b1) begin
            errors++;
            $display("FAIL link_taken: got %h want lpw/2A/10", obs());
        end
        n = 0;
        for (int i = 0; i < 8; i++) begin
            if (flush_if === 1'b1) n++;
            stall = (i < 2);
            tick();
            if (i == 0) begin
                checks++;
                if (link_pc_we !== 1'b0 || BrTaken !== 1'b0) begin
                    errors++;
                    $display("FAIL link_pulse_width: got lpw=%b br=%b want 0 0", link_pc_we, BrTaken);
                end
            end
        end
        stall = 0;
        checks++;
        if (n != FC + 2) begin
            errors++;
            $display("FAIL link_flush_extend: got %0d cycles want %0d", n, FC + 2);
        end
    endtask

    task automatic test_random();
        int r;
        for (int i = 0; i < 600; i++) begin
            reset = ($urandom_range(0, 59) == 0);
            instr_valid = ($urandom_range(0, 3) != 0);
            stall = ($urandom_range(0, 4) == 0);
            flags_we = ($urandom_range(0, 2) == 0);
            alu_flags = 4'($urandom);
            rd2 = 16'($urandom);
            r = $urandom_range(0, 5);
            case (r)
                0, 1: instr = {4'hC, 4'($urandom), 8'($urandom)};
                2: instr = {5'b11010, 11'($urandom)};
                3: instr = {5'b11011, 11'($urandom)};
                4: instr = {5'b11100, 11'($urandom)};
                default: instr = 16'($urandom);
            endcase
            tick();
            checks++;
            if (o_sr !== e_sr) begin
                errors++;
                $display("FAIL rand_stall_req: got %b want %b", o_sr, e_sr);
            end
            checks++;
            if (obs() !== expv()) begin
                errors++;
                $display("FAIL rand_outputs: got %h want %h", obs(), expv());
            end
        end
        reset = 0; quiet();
    endtask

    initial begin
        mf = 0; fl = 0; m_ca = 0; m_ua = 0; m_la = 0; m_rt = 0;
        m_bt = 0; m_tk = 0; m_rb = 0; m_lpw = 0; e_sr = 0; o_sr = 0;
        test_reset();
        test_cond_eq();
        test_cond_ne();
        test_register();
        test_collision();
        test_link_stall();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
